uart_sr_output: RTL and testbench

Parallel-to-stream character serializer for the UART transmit path, the counterpart of uart_sr_input.
- Accepts a packed buffer of up to CHARACTER_COUNT characters plus a character count in one load handshake.
- Streams the characters one at a time over a valid/ready interface that drives the UART transmitter's tx_data/tx_valid/tx_ready.
- Sits between message-producing logic and the UART transmitter. Signals completion with a one-cycle done pulse.

---
 rtl/uart_sr_output.sv | 140 ++++++++++++++
 tb/tb_uart_sr_output.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sr_output.sv
// uart_sr_output
// Parallel-to-stream character serializer for the UART transmit path.
// A packed buffer of up to CHARACTER_COUNT characters is captured in a single
// load handshake and then presented to the UART transmitter one character at
// a time over a valid/ready interface. Character 0 sits in the top DATA_WIDTH
// bits of load_data and goes out first. A one-cycle done pulse follows the
// last accepted character.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   ena         global enable; low freezes all state and blocks both handshakes
//   load_data   packed character buffer (character 0 in the top bits)
//   load_count  number of characters to send (clamped to CHARACTER_COUNT)
//   load_valid  load request
//   load_ready  block can accept a load
//   tx_data     character to the UART transmitter
//   tx_valid    tx_data is valid
//   tx_ready    UART transmitter accepts tx_data
//   busy        transfer in progress (SEND or DONE)
//   done        one-cycle pulse after the last character is accepted
module uart_sr_output #(
    parameter int DATA_WIDTH      = 8,
    parameter int CHARACTER_COUNT = 10,
    parameter int CNT_W           = $clog2(CHARACTER_COUNT + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ena,
    input  logic [DATA_WIDTH*CHARACTER_COUNT-1:0] load_data,
    input  logic [CNT_W-1:0]                      load_count,
    input  logic                                  load_valid,
    output logic                                  load_ready,
    output logic [DATA_WIDTH-1:0]                 tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  done
);

    localparam int               BUF_W     = DATA_WIDTH * CHARACTER_COUNT;
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(CHARACTER_COUNT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [BUF_W-1:0] buffer;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] eff_count;
    logic             load_fire;
    logic             tx_fire;

    // Oversized counts are clamped so no more than the buffer holds is sent.
    always_comb begin
        eff_count = load_count;
        if (load_count > MAX_COUNT) begin
            eff_count = MAX_COUNT;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs. Handshake outputs are gated by ena so that
    // nothing can complete while the block is frozen.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        tx_valid   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = ena;
                if (load_valid && ena) begin
                    state_next = (eff_count == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                tx_valid = ena;
                // remaining <= 1 also covers a stray zero so SEND cannot stall.
                if (ena && tx_ready && (remaining <= ONE)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // State holds while ena is low, so gating keeps the pulse to
                // exactly one enabled cycle.
                done = ena;
                if (ena) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign load_fire = load_valid && load_ready;
    assign tx_fire   = tx_valid && tx_ready;
    assign busy      = (state != IDLE);
    assign tx_data   = buffer[BUF_W-1 -: DATA_WIDTH];

    // ------------------------------------------------------------------
    // Character buffer and remaining-count datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer    <= '0;
            remaining <= '0;
        end else if (ena) begin
            if (load_fire) begin
                buffer    <= load_data;
                remaining <= eff_count;
            end else if (tx_fire) begin
                buffer <= {buffer[BUF_W-DATA_WIDTH-1:0], DATA_WIDTH'(0)};
                if (remaining != '0) begin
                    remaining <= remaining - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_sr_output.sv
// Self-checking bench for uart_sr_output: directed loads with hand-computed
// character sequences, backpressure, count boundaries, enable freeze and
// reset abort.
module tb_uart_sr_output;

    localparam int DATA_WIDTH      = 8;
    localparam int CHARACTER_COUNT = 10;
    localparam int CNT_W           = $clog2(CHARACTER_COUNT + 1);
    localparam int BUF_W           = DATA_WIDTH * CHARACTER_COUNT;

    logic             clk;
    logic             reset;
    logic             ena;
    logic [BUF_W-1:0] load_data;
    logic [CNT_W-1:0] load_count;
    logic             load_valid;
    logic             load_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    uart_sr_output #(
        .DATA_WIDTH     (DATA_WIDTH),
        .CHARACTER_COUNT(CHARACTER_COUNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .load_data (load_data),
        .load_count(load_count),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the load edge.
    task automatic do_load(input string name, input logic [BUF_W-1:0] data,
                           input logic [CNT_W-1:0] cnt);
        load_data  = data;
        load_count = cnt;
        load_valid = 1'b1;
        tx_ready   = 1'b0;
        #1;
        check({name, " load_ready"}, 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    // Follows a transfer cycle by cycle. Cycle 0 is the first cycle after
    // the load edge. rdy bit (cyc%32) drives tx_ready; ena is held low for
    // three cycles starting at freeze_at (negative disables the freeze).
    task automatic stream(input string name, input int n, input logic [31:0] rdy,
                          input int freeze_at, input int done_cyc);
        int         got;
        bit         finished;
        bit         last_hs;
        bit         holding;
        logic [7:0] held;
        got      = 0;
        finished = 1'b0;
        last_hs  = 1'b0;
        holding  = 1'b0;
        held     = '0;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            tx_ready = rdy[cyc % 32];
            ena      = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 3);
            #1;
            if (cyc == 0) begin
                check({name, " first tx_valid"}, 32'(tx_valid), 32'(n > 0));
                check({name, " busy"}, 32'(busy), 32'd1);
                check({name, " load_ready while busy"}, 32'(load_ready), 32'd0);
            end
            if (!ena) begin
                check({name, " frozen tx_valid"}, 32'(tx_valid), 32'd0);
            end
            if (holding && ena) begin
                check({name, " held data"}, 32'(tx_data), 32'(held));
            end
            if (done) begin
                check({name, " done timing"}, 32'(cyc), 32'(done_cyc));
                check({name, " done after last"}, 32'(n == 0 || (last_hs && got == n)), 32'd1);
                check({name, " tx_valid in done"}, 32'(tx_valid), 32'd0);
                finished = 1'b1;
            end else if (tx_valid && tx_ready) begin
                if (got < n) begin
                    check($sformatf("%s byte %0d", name, got), 32'(tx_data), 32'(exp_q[got]));
                end else begin
                    check({name, " extra handshake"}, 32'(got), 32'(n - 1));
                end
                got++;
                last_hs = 1'b1;
                holding = 1'b0;
            end else begin
                if (ena) begin
                    last_hs = 1'b0;
                    holding = tx_valid;
                    held    = tx_data;
                end
            end
            if (!finished) begin
                @(posedge clk);
                #1;
            end
        end
        ena = 1'b1;
        check({name, " handshakes"}, 32'(got), 32'(n));
        check({name, " done seen"}, 32'(finished), 32'd1);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        #1;
        check({name, " idle load_ready"}, 32'(load_ready), 32'd1);
        check({name, " idle busy"}, 32'(busy), 32'd0);
        check({name, " idle done"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [BUF_W-1:0] hello;
    logic [BUF_W-1:0] ramp;

    initial begin
        hello = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 40'h0};
        ramp  = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};

        reset      = 1'b1;
        ena        = 1'b1;
        load_data  = '0;
        load_count = '0;
        load_valid = 1'b0;
        tx_ready   = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post-reset load_ready", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic: five back-to-back characters, done on cycle 5.
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        do_load("basic", hello, 4'd5);
        stream("basic", 5, 32'hFFFF_FFFF, -1, 5);

        // Backpressure 1,0,0 repeating: handshakes on cycles 0,3,6,9,12.
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        do_load("bp", hello, 4'd5);
        stream("bp", 5, 32'h4924_9249, -1, 13);

        // Zero count: straight to DONE.
        exp_q = '{};
        do_load("zero", hello, 4'd0);
        stream("zero", 0, 32'hFFFF_FFFF, -1, 0);

        // Count 15 clamps to 10; last byte is the bottom byte 0x0A.
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        do_load("clamp", ramp, 4'd15);
        stream("clamp", 10, 32'hFFFF_FFFF, -1, 10);

        // Freeze on cycles 2..4: handshakes on 0,1,5,6,7, done on 8.
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        do_load("freeze", hello, 4'd5);
        stream("freeze", 5, 32'hFFFF_FFFF, 2, 8);

        // Reset after two characters have been accepted.
        do_load("abort", hello, 4'd5);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort third byte", 32'(tx_data), 32'h4C);
        reset = 1'b1;
        #1;
        check("abort tx_valid", 32'(tx_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("abort done held", 32'(done), 32'd0);
        reset    = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_q = '{8'hA5};
        do_load("single", {8'hA5, 72'h0}, 4'd1);
        stream("single", 1, 32'hFFFF_FFFF, -1, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
